byte_lane_regfile: RTL and testbench

BYTE_LANE_REGFILE -- requirements
Module: byte_lane_regfile

---
 rtl/byte_lane_regfile.sv | 85 ++++++++
 tb/tb_byte_lane_regfile.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/byte_lane_regfile.sv
// byte_lane_regfile: DEPTH x (8*BYTES) register file with per-byte write
// enables, two combinational read ports with same-cycle write bypass,
// per-register dirty flags, an optional hardwired-zero register 0, and a
// synchronous clear.
module byte_lane_regfile #(
   parameter int  BYTES    = 2,
   parameter int  DEPTH    = 8,
   parameter int  ZERO_REG = 1,
   localparam int W        = 8 * BYTES,
   localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             res,
   input  logic             clr,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [BYTES-1:0] wbe,
   input  logic [W-1:0]     wdata,
   input  logic [AW-1:0]    raddr_a,
   input  logic [AW-1:0]    raddr_b,
   output logic [W-1:0]     rdata_a,
   output logic [W-1:0]     rdata_b,
   output logic [DEPTH-1:0] dirty
);

   logic [W-1:0]     regs [DEPTH];
   logic             write_ok;
   logic [BYTES-1:0] lane_we;
   logic [AW-1:0]    rd_addr [2];
   logic [W-1:0]     rd_data [2];

   // An address is backed by storage when it lies inside DEPTH and is not the
   // hardwired zero register. The extra compare bit keeps the test meaningful
   // when DEPTH is a power of two.
   function automatic logic addr_ok(input logic [AW-1:0] a);
      return ({1'b0, a} < (AW + 1)'(DEPTH)) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   // A write counts only out of reset, outside a clear, and to a real register.
   assign write_ok = res && !clr && we && addr_ok(waddr);
   assign lane_we  = write_ok ? wbe : '0;

   // Storage and dirty flags: async reset, sync clear, per-lane write.
   // NOTE: the array is built from resettable flops on purpose; contents must
   // read as zero the moment reset asserts, which a RAM macro cannot provide.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
         dirty <= '0;
      end else if (clr) begin
         for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
         dirty <= '0;
      end else if (|lane_we) begin
         for (int i = 0; i < BYTES; i++) begin
            if (lane_we[i]) regs[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
         dirty[waddr] <= 1'b1;
      end
   end

   assign rd_addr[0] = raddr_a;
   assign rd_addr[1] = raddr_b;

   // Both read ports: stored value, overlaid lane-by-lane with a legal
   // same-cycle write to the same address; unbacked addresses read zero.
   // NOTE: every output gets a default before any condition so no latch is
   // inferred when an address is out of range.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_data[p] = '0;
         if (addr_ok(rd_addr[p])) begin
            rd_data[p] = regs[rd_addr[p]];
            if (write_ok && (waddr == rd_addr[p])) begin
               for (int i = 0; i < BYTES; i++) begin
                  if (wbe[i]) rd_data[p][8*i +: 8] = wdata[8*i +: 8];
               end
            end
         end
      end
   end

   assign rdata_a = rd_data[0];
   assign rdata_b = rd_data[1];

endmodule

// File: tb/tb_byte_lane_regfile.sv
// Directed self-checking bench for byte_lane_regfile. Three instances share
// stimulus: default parameters, ZERO_REG=0, and DEPTH=6.
module tb_byte_lane_regfile;

   logic        clk;
   logic        res;
   logic        clr;
   logic        we;
   logic [2:0]  waddr;
   logic [1:0]  wbe;
   logic [15:0] wdata;
   logic [2:0]  raddr_a;
   logic [2:0]  raddr_b;

   logic [15:0] rdata_a,    rdata_b;
   logic [7:0]  dirty;
   logic [15:0] z0_rdata_a, z0_rdata_b;
   logic [7:0]  z0_dirty;
   logic [15:0] d6_rdata_a, d6_rdata_b;
   logic [5:0]  d6_dirty;

   int checks;
   int failures;

   byte_lane_regfile dut (
      .clk(clk), .res(res), .clr(clr), .we(we), .waddr(waddr), .wbe(wbe),
      .wdata(wdata), .raddr_a(raddr_a), .raddr_b(raddr_b),
      .rdata_a(rdata_a), .rdata_b(rdata_b), .dirty(dirty)
   );

   byte_lane_regfile #(.ZERO_REG(0)) dut_z0 (
      .clk(clk), .res(res), .clr(clr), .we(we), .waddr(waddr), .wbe(wbe),
      .wdata(wdata), .raddr_a(raddr_a), .raddr_b(raddr_b),
      .rdata_a(z0_rdata_a), .rdata_b(z0_rdata_b), .dirty(z0_dirty)
   );

   byte_lane_regfile #(.DEPTH(6)) dut_d6 (
      .clk(clk), .res(res), .clr(clr), .we(we), .waddr(waddr), .wbe(wbe),
      .wdata(wdata), .raddr_a(raddr_a), .raddr_b(raddr_b),
      .rdata_a(d6_rdata_a), .rdata_b(d6_rdata_b), .dirty(d6_dirty)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] actual,
                        input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   // One write cycle; inputs return idle just after the capturing edge.
   task automatic do_write(input logic [2:0] a, input logic [1:0] be,
                           input logic [15:0] d);
      we = 1'b1; waddr = a; wbe = be; wdata = d;
      @(posedge clk);
      #1;
      we = 1'b0; wbe = '0; wdata = '0;
      #1;
   endtask

   initial begin
      checks = 0; failures = 0;
      res = 1'b0; clr = 1'b0; we = 1'b0; waddr = '0; wbe = '0; wdata = '0;
      raddr_a = 3'd3; raddr_b = 3'd3;

      // Reset state
      #3;
      check("reset_rdata_a", 32'(rdata_a), 32'h0);
      check("reset_dirty",   32'(dirty),   32'h0);
      @(negedge clk);
      res = 1'b1;
      @(negedge clk);

      // Reset then full write to reg3
      do_write(3'd3, 2'b11, 16'hA5C3);
      check("wr3_rdata",  32'(rdata_a), 32'hA5C3);
      check("wr3_dirty",  32'(dirty),   32'h08);

      // Upper lane only, then empty lane mask
      do_write(3'd3, 2'b10, 16'h1234);
      check("lane_hi",    32'(rdata_a), 32'h12C3);
      do_write(3'd3, 2'b00, 16'hFFFF);
      check("lane_none",  32'(rdata_a), 32'h12C3);
      check("lane_none_dirty", 32'(dirty), 32'h08);
      do_write(3'd2, 2'b00, 16'hFFFF);
      check("wbe0_clean_dirty", 32'(dirty), 32'h08);

      // Bypass on both ports
      do_write(3'd5, 2'b11, 16'h00FF);
      check("wr5_dirty", 32'(dirty), 32'h28);
      raddr_a = 3'd5; raddr_b = 3'd5;
      we = 1'b1; waddr = 3'd5; wbe = 2'b01; wdata = 16'h7777;
      #1;
      check("bypass_a", 32'(rdata_a), 32'h0077);
      check("bypass_b", 32'(rdata_b), 32'h0077);
      @(posedge clk);
      #1;
      we = 1'b0; wbe = '0;
      #1;
      check("bypass_stored", 32'(rdata_a), 32'h0077);

      // Zero register
      @(negedge clk);
      raddr_a = 3'd0;
      we = 1'b1; waddr = 3'd0; wbe = 2'b11; wdata = 16'hBEEF;
      #1;
      check("zero_before",    32'(rdata_a),    32'h0);
      check("z0_bypass",      32'(z0_rdata_a), 32'hBEEF);
      @(posedge clk);
      #1;
      we = 1'b0; wbe = '0;
      #1;
      check("zero_after",     32'(rdata_a),    32'h0);
      check("zero_dirty",     32'(dirty),      32'h28);
      check("z0_after",       32'(z0_rdata_a), 32'hBEEF);
      check("z0_dirty",       32'(z0_dirty),   32'h29);

      // DEPTH=6: address 7 ignored there, real on the 8-deep instance
      @(negedge clk);
      raddr_b = 3'd7;
      we = 1'b1; waddr = 3'd7; wbe = 2'b11; wdata = 16'hCAFE;
      #1;
      check("d6_oob_bypass", 32'(d6_rdata_b), 32'h0);
      check("main_7_bypass", 32'(rdata_b),    32'hCAFE);
      @(posedge clk);
      #1;
      we = 1'b0; wbe = '0;
      #1;
      check("d6_oob_read",  32'(d6_rdata_b), 32'h0);
      check("d6_oob_dirty", 32'(d6_dirty),   32'h28);
      check("main_7_dirty", 32'(dirty),      32'hA8);
      check("main_7_read",  32'(rdata_b),    32'hCAFE);

      // Clear beats a simultaneous write; no bypass during clear
      @(negedge clk);
      raddr_a = 3'd2; raddr_b = 3'd3;
      clr = 1'b1; we = 1'b1; waddr = 3'd2; wbe = 2'b11; wdata = 16'h5555;
      #1;
      check("clr_no_bypass", 32'(rdata_a), 32'h0);
      check("clr_stored_b",  32'(rdata_b), 32'h12C3);
      @(posedge clk);
      #1;
      clr = 1'b0; we = 1'b0; wbe = '0;
      #1;
      check("clr_reg2",  32'(rdata_a), 32'h0);
      check("clr_reg3",  32'(rdata_b), 32'h0);
      check("clr_dirty", 32'(dirty),   32'h0);

      // Async reset between edges, then a write held during reset
      @(negedge clk);
      do_write(3'd4, 2'b11, 16'hABCD);
      raddr_a = 3'd4; raddr_b = 3'd6;
      #1;
      check("pre_rst_data",  32'(rdata_a), 32'hABCD);
      check("pre_rst_dirty", 32'(dirty),   32'h10);
      @(negedge clk);
      #1;
      res = 1'b0;
      #1;
      check("async_rst_data",  32'(rdata_a), 32'h0);
      check("async_rst_dirty", 32'(dirty),   32'h0);
      we = 1'b1; waddr = 3'd6; wbe = 2'b11; wdata = 16'h9999;
      @(posedge clk);
      #1;
      check("rst_write_ignored", 32'(rdata_b), 32'h0);
      check("rst_write_dirty",   32'(dirty),   32'h0);
      @(negedge clk);
      we = 1'b0; wbe = '0;
      res = 1'b1;
      #1;
      do_write(3'd6, 2'b11, 16'h1111);
      check("post_rst_write", 32'(rdata_b), 32'h1111);
      check("post_rst_dirty", 32'(dirty),   32'h40);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
